// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - byte-stream input and instruction-memory write port of the program loader
interface imem_program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - loads a checksummed program frame into instruction memory, then releases the core
module imem_program_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_program_loader_if.master bus,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W:0]       words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t      state, state_nx;
    logic        in_ready_c;
    logic        accept;
    logic        start_ok;
    logic [7:0]  cnt_lo;
    logic [15:0] cnt;
    logic [15:0] hdr_cnt;
    logic        hdr_overflow;
    logic [1:0]  byte_idx;
    logic [23:0] word_asm;
    logic [7:0]  xor_acc;
    logic [ADDR_W:0] words_nx;
    logic        last_word;

    assign in_ready_c   = (state == S_HDR0) || (state == S_HDR1) ||
                          (state == S_DATA) || (state == S_CHK);
    assign accept       = in_ready_c && bus.in_valid;
    assign bus.in_ready = in_ready_c;
    assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign hdr_cnt      = {bus.in_data, cnt_lo};
    assign hdr_overflow = {1'b0, hdr_cnt} > MAX_WORDS;
    assign words_nx     = words_loaded + 1'b1;
    assign last_word    = 17'(words_nx) == {1'b0, cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nx = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_nx = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    if (hdr_overflow)      state_nx = S_ERR;
                    else if (hdr_cnt == 0) state_nx = S_CHK;
                    else                   state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_nx = S_CHK;
            end
            S_CHK: begin
                if (accept) state_nx = (bus.in_data == xor_acc) ? S_DONE : S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset     <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
            cnt_lo         <= '0;
            cnt            <= '0;
            byte_idx       <= '0;
            word_asm       <= '0;
            xor_acc        <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            if (start_ok) begin
                core_reset   <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
                words_loaded <= '0;
                byte_idx     <= '0;
                xor_acc      <= '0;
            end
            case (state)
                S_HDR0: begin
                    if (accept) cnt_lo <= bus.in_data;
                end
                S_HDR1: begin
                    if (accept) begin
                        cnt <= hdr_cnt;
                        if (hdr_overflow) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        xor_acc  <= xor_acc ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte completes the word; it goes straight to the write port.
                        if (byte_idx == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
                            bus.imem_wdata <= {bus.in_data, word_asm};
                            words_loaded   <= words_nx;
                        end else begin
                            word_asm[8*byte_idx +: 8] <= bus.in_data;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (bus.in_data == xor_acc) begin
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed checks of imem_program_loader framing, checksum and reset behaviour
module tb_imem_program_loader;
    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            core_reset;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  f1[15]      = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h70, 8'h00, 8'h03, 8'h01,
                                 8'h00, 8'h00, 8'h33, 8'h82, 8'h20, 8'h40, 8'h30};
    logic [7:0]  exp_addr[3] = '{8'd0, 8'd1, 8'd2};
    logic [31:0] exp_data[3] = '{32'h00700093, 32'h00000103, 32'h40208233};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("in_ready timeout", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_f1(input logic [7:0] chk_flip, input int maxgap, input string pfx);
        for (int i = 0; i < 14; i++)
            send_byte(f1[i], (maxgap > 0) ? $urandom_range(maxgap, 1) : 0);
        check({pfx, " core_reset before chk"}, {31'b0, core_reset}, 32'd1);
        send_byte(f1[14] ^ chk_flip, (maxgap > 0) ? $urandom_range(maxgap, 1) : 0);
    endtask

    task automatic check_f1_writes(input int base, input string pfx);
        repeat (2) @(posedge clk);
        #1;
        check({pfx, " write count"}, wr_addr.size() - base, 32'd3);
        if (wr_addr.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s addr%0d", pfx, i), {24'b0, wr_addr[base+i]}, {24'b0, exp_addr[i]});
                check($sformatf("%s data%0d", pfx, i), wr_data[base+i], exp_data[i]);
            end
        end
        check({pfx, " words_loaded"}, {23'b0, words_loaded}, 32'd3);
    endtask

    task automatic check_done(input string pfx);
        check({pfx, " done"}, {31'b0, done}, 32'd1);
        check({pfx, " core_reset"}, {31'b0, core_reset}, 32'd0);
        check({pfx, " error"}, {31'b0, error}, 32'd0);
        check({pfx, " in_ready"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset core_reset", {31'b0, core_reset}, 32'd1);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset error", {31'b0, error}, 32'd0);
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("reset imem_we", {31'b0, bus.imem_we}, 32'd0);
        check("reset words_loaded", {23'b0, words_loaded}, 32'd0);

        // Test 1: three-word image, correct checksum
        base = wr_addr.size();
        pulse_start();
        check("t1 in_ready after start", {31'b0, bus.in_ready}, 32'd1);
        send_f1(8'h00, 0, "t1");
        check_done("t1");
        check_f1_writes(base, "t1");

        // Test 2: bad checksum
        base = wr_addr.size();
        pulse_start();
        check("t2 done cleared by start", {31'b0, done}, 32'd0);
        check("t2 core_reset by start", {31'b0, core_reset}, 32'd1);
        send_f1(8'h01, 0, "t2");
        check("t2 error", {31'b0, error}, 32'd1);
        check("t2 done", {31'b0, done}, 32'd0);
        check("t2 core_reset", {31'b0, core_reset}, 32'd1);
        check_f1_writes(base, "t2");

        // Test 3: CNT = 0x0101 overflows a 256-word memory
        base = wr_addr.size();
        pulse_start();
        check("t3 error cleared by start", {31'b0, error}, 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t3 error", {31'b0, error}, 32'd1);
        check("t3 in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("t3 core_reset", {31'b0, core_reset}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t3 write count", wr_addr.size() - base, 32'd0);
        check("t3 words_loaded", {23'b0, words_loaded}, 32'd0);

        // Test 4: empty image, then a full reload
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_done("t4 empty");
        check("t4 empty words_loaded", {23'b0, words_loaded}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t4 empty write count", wr_addr.size() - base, 32'd0);
        base = wr_addr.size();
        pulse_start();
        send_f1(8'h00, 0, "t4 reload");
        check_done("t4 reload");
        check_f1_writes(base, "t4 reload");

        // Test 5: random valid gaps between bytes
        base = wr_addr.size();
        pulse_start();
        send_f1(8'h00, 5, "t5");
        check_done("t5");
        check_f1_writes(base, "t5");

        // Test 6: reset after the 6th data byte
        base = wr_addr.size();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(f1[i], 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6 core_reset", {31'b0, core_reset}, 32'd1);
        check("t6 done", {31'b0, done}, 32'd0);
        check("t6 in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("t6 imem_we", {31'b0, bus.imem_we}, 32'd0);
        check("t6 words_loaded", {23'b0, words_loaded}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6 writes before reset only", wr_addr.size() - base, 32'd1);
        base = wr_addr.size();
        pulse_start();
        send_f1(8'h00, 0, "t6 reload");
        check_done("t6 reload");
        check_f1_writes(base, "t6 reload");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
